fft8_frame_ctrl: RTL and testbench

FFT8_FRAME_CTRL -- requirements
Module: fft8_frame_ctrl

---
 rtl/fft8_pkg.sv | 18 +
 rtl/fft8_sample_buf.sv | 65 ++++++
 rtl/fft8_frame_ctrl.sv | 137 +++++++++++++
 tb/tb_fft8_frame_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared constants and FSM state type for the 8-point FFT frame controller.
package fft8_pkg;

  localparam int unsigned FFT_N = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned DW    = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/fft8_sample_buf.sv
// 8-entry complex sample buffer: serial write by index, parallel load,
// parallel read and serial read by index. Used for both input and output sides.
module fft8_sample_buf #(
  parameter int unsigned DW = fft8_pkg::DW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wr_en,
  input  logic [2:0]           wr_idx,
  input  logic [DW-1:0]        wr_real,
  input  logic [DW-1:0]        wr_imag,
  input  logic                 zero_tail,
  input  logic                 ld_en,
  input  logic [8*DW-1:0]      ld_real,
  input  logic [8*DW-1:0]      ld_imag,
  output logic [8*DW-1:0]      par_real,
  output logic [8*DW-1:0]      par_imag,
  input  logic [2:0]           rd_idx,
  output logic [DW-1:0]        rd_real,
  output logic [DW-1:0]        rd_imag
);
  import fft8_pkg::*;

  logic [DW-1:0] mem_re [FFT_N];
  logic [DW-1:0] mem_im [FFT_N];

  // A serial write with zero_tail also clears every slot above wr_idx,
  // so a short frame never carries stale samples from the previous one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < FFT_N; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
    end else if (ld_en) begin
      for (int unsigned i = 0; i < FFT_N; i++) begin
        mem_re[i] <= ld_real[i*DW +: DW];
        mem_im[i] <= ld_imag[i*DW +: DW];
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < FFT_N; i++) begin
        if (IDX_W'(i) == wr_idx) begin
          mem_re[i] <= wr_real;
          mem_im[i] <= wr_imag;
        end else if (zero_tail && (IDX_W'(i) > wr_idx)) begin
          mem_re[i] <= '0;
          mem_im[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    par_real = '0;
    par_imag = '0;
    for (int unsigned i = 0; i < FFT_N; i++) begin
      par_real[i*DW +: DW] = mem_re[i];
      par_imag[i*DW +: DW] = mem_im[i];
    end
  end

  assign rd_real = mem_re[rd_idx];
  assign rd_imag = mem_im[rd_idx];

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame controller around an external 8-point FFT core: gathers 8 serial samples,
// loads and starts the core, captures its results and streams the 8 bins out.
module fft8_frame_ctrl #(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned DW           = fft8_pkg::DW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_real,
  input  logic [DW-1:0]     s_imag,
  input  logic              s_last,
  output logic [8*DW-1:0]   core_in_real,
  output logic [8*DW-1:0]   core_in_imag,
  output logic              core_write,
  output logic              core_start,
  input  logic [8*DW-1:0]   core_out_real,
  input  logic [8*DW-1:0]   core_out_imag,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_real,
  output logic [DW-1:0]     m_imag,
  output logic [2:0]        m_index,
  output logic              m_last,
  output logic              busy,
  output logic              frame_err
);
  import fft8_pkg::*;

  state_t           state;
  logic [IDX_W-1:0] fill_cnt;
  logic [IDX_W-1:0] run_cnt;
  logic [IDX_W-1:0] bin_idx;
  logic             accept;
  logic             at_slot7;
  logic [DW-1:0]    unused_in_rd_re;
  logic [DW-1:0]    unused_in_rd_im;
  logic [8*DW-1:0]  unused_out_par_re;
  logic [8*DW-1:0]  unused_out_par_im;

  assign accept   = s_valid && s_ready;
  assign at_slot7 = (fill_cnt == LAST_IDX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_FILL;
      fill_cnt  <= '0;
      run_cnt   <= '0;
      bin_idx   <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            fill_cnt <= fill_cnt + IDX_W'(1);
            // s_last belongs exactly on slot 7; any other pairing flags the frame
            if (at_slot7 || s_last) begin
              state    <= ST_LOAD;
              fill_cnt <= '0;
              if (at_slot7 != s_last) frame_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state   <= ST_RUN;
          run_cnt <= '0;
        end
        ST_RUN: begin
          if (run_cnt == IDX_W'(START_CYCLES - 1)) state <= ST_CAPTURE;
          else run_cnt <= run_cnt + IDX_W'(1);
        end
        ST_CAPTURE: begin
          state   <= ST_DRAIN;
          bin_idx <= '0;
        end
        ST_DRAIN: begin
          if (m_ready) begin
            if (bin_idx == LAST_IDX) begin
              state   <= ST_FILL;
              bin_idx <= '0;
            end else begin
              bin_idx <= bin_idx + IDX_W'(1);
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Strobes are gated by RST so they stay quiet even before the first reset edge.
  assign s_ready    = !RST && (state == ST_FILL);
  assign core_write = !RST && (state == ST_LOAD);
  assign core_start = !RST && (state == ST_RUN);
  assign m_valid    = !RST && (state == ST_DRAIN);
  assign m_last     = m_valid && (bin_idx == LAST_IDX);
  assign m_index    = RST ? '0 : bin_idx;
  assign busy       = !RST && ((state != ST_FILL) || (fill_cnt != '0));

  fft8_sample_buf #(.DW(DW)) u_in_buf (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en     (accept),
    .wr_idx    (fill_cnt),
    .wr_real   (s_real),
    .wr_imag   (s_imag),
    .zero_tail (s_last),
    .ld_en     (1'b0),
    .ld_real   ('0),
    .ld_imag   ('0),
    .par_real  (core_in_real),
    .par_imag  (core_in_imag),
    .rd_idx    ('0),
    .rd_real   (unused_in_rd_re),
    .rd_imag   (unused_in_rd_im)
  );

  fft8_sample_buf #(.DW(DW)) u_out_buf (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_real   ('0),
    .wr_imag   ('0),
    .zero_tail (1'b0),
    .ld_en     (state == ST_CAPTURE),
    .ld_real   (core_out_real),
    .ld_imag   (core_out_imag),
    .par_real  (unused_out_par_re),
    .par_imag  (unused_out_par_im),
    .rd_idx    (bin_idx),
    .rd_real   (m_real),
    .rd_imag   (m_imag)
  );

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl with a bin-reversing core model.
module tb_fft8_frame_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned SC = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic            s_valid, s_ready, s_last;
  logic [DW-1:0]   s_real, s_imag;
  logic [8*DW-1:0] core_in_real, core_in_imag, core_out_real, core_out_imag;
  logic            core_write, core_start;
  logic            m_valid, m_ready, m_last;
  logic [DW-1:0]   m_real, m_imag;
  logic [2:0]      m_index;
  logic            busy, frame_err;

  fft8_frame_ctrl #(.START_CYCLES(SC), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .core_in_real(core_in_real), .core_in_imag(core_in_imag),
    .core_write(core_write), .core_start(core_start),
    .core_out_real(core_out_real), .core_out_imag(core_out_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .busy(busy), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  // Core model: latch operands on core_write, return bin k = sample 7-k.
  logic [8*DW-1:0] mdl_re = '0;
  logic [8*DW-1:0] mdl_im = '0;
  always @(posedge CLK) if (core_write) begin
    mdl_re <= core_in_real;
    mdl_im <= core_in_imag;
  end
  always_comb begin
    core_out_real = '0;
    core_out_imag = '0;
    for (int k = 0; k < 8; k++) begin
      core_out_real[k*DW +: DW] = mdl_re[(7-k)*DW +: DW];
      core_out_imag[k*DW +: DW] = mdl_im[(7-k)*DW +: DW];
    end
  end

  int unsigned   cw_cnt = 0, cs_cnt = 0, both_cnt = 0;
  logic [DW-1:0] bq_re[$], bq_im[$];
  logic [2:0]    bq_idx[$];
  logic          bq_last[$];
  time           bq_t[$], acc_t[$];
  always @(posedge CLK) begin
    if (core_write) cw_cnt++;
    if (core_start) cs_cnt++;
    if (core_write && core_start) both_cnt++;
    if (m_valid && m_ready) begin
      bq_re.push_back(m_real);
      bq_im.push_back(m_imag);
      bq_idx.push_back(m_index);
      bq_last.push_back(m_last);
      bq_t.push_back($time);
    end
    if (s_valid && s_ready) acc_t.push_back($time);
  end

  int unsigned vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] neg(input int x);
    return DW'(-x);
  endfunction

  task automatic send_beat(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
    int unsigned t = 0;
    s_valid = 1'b1; s_real = re; s_imag = im; s_last = last;
    while (!s_ready && t < 60) begin tick(); t++; end
    check("s_ready_wait", {63'b0, s_ready}, 64'd1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_beats(input int unsigned target);
    int unsigned t = 0;
    while (bq_re.size() < target && t < 200) begin tick(); t++; end
    check("beat_count", 64'(bq_re.size()), 64'(target));
  endtask

  initial begin
    int unsigned b0, a0, cw0, cs0, nb;
    logic [2:0]    p_idx;
    logic [DW-1:0] p_re, p_im;
    logic          rdy;
    int            s;

    RST = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0; m_ready = 1'b1;
    tick(); tick();
    check("rst_s_ready",    {63'b0, s_ready},    64'd0);
    check("rst_core_write", {63'b0, core_write}, 64'd0);
    check("rst_core_start", {63'b0, core_start}, 64'd0);
    check("rst_m_valid",    {63'b0, m_valid},    64'd0);
    check("rst_m_last",     {63'b0, m_last},     64'd0);
    check("rst_m_index",    64'(m_index),        64'd0);
    check("rst_busy",       {63'b0, busy},       64'd0);
    check("rst_frame_err",  {63'b0, frame_err},  64'd0);
    check("rst_m_real",     64'(m_real),         64'd0);
    check("rst_core_in",    {63'b0, |{core_in_real, core_in_imag}}, 64'd0);
    RST = 1'b0; #1;
    check("s_ready_after_rst", {63'b0, s_ready}, 64'd1);

    // Frame 1: sample k = (k+1, -(k+1)), timing and reversed bins
    b0 = 0; cw0 = cw_cnt; cs0 = cs_cnt;
    send_beat(DW'(1), neg(1), 1'b0);
    check("f1_busy_partial", {63'b0, busy}, 64'd1);
    for (int k = 1; k < 8; k++) send_beat(DW'(k+1), neg(k+1), k == 7);
    check("f1_load_write",  {63'b0, core_write}, 64'd1);
    check("f1_load_start",  {63'b0, core_start}, 64'd0);
    check("f1_load_sready", {63'b0, s_ready},    64'd0);
    tick();
    check("f1_run1_start",  {63'b0, core_start}, 64'd1);
    check("f1_run1_write",  {63'b0, core_write}, 64'd0);
    tick();
    check("f1_run2_start",  {63'b0, core_start}, 64'd1);
    tick();
    check("f1_cap_start",   {63'b0, core_start}, 64'd0);
    check("f1_cap_valid",   {63'b0, m_valid},    64'd0);
    tick();
    check("f1_first_valid", {63'b0, m_valid},    64'd1);
    check("f1_first_index", 64'(m_index),        64'd0);
    wait_beats(b0 + 8);
    check("f1_write_cycles", 64'(cw_cnt - cw0), 64'd1);
    check("f1_start_cycles", 64'(cs_cnt - cs0), 64'd2);
    for (int k = 0; k < 8; k++) begin
      check("f1_bin_real",  64'(bq_re[b0+k]),   64'(8 - k));
      check("f1_bin_imag",  64'(bq_im[b0+k]),   64'(neg(8 - k)));
      check("f1_bin_index", 64'(bq_idx[b0+k]),  64'(k));
      check("f1_bin_last",  {63'b0, bq_last[b0+k]}, {63'b0, k == 7});
    end
    check("f1_frame_err", {63'b0, frame_err}, 64'd0);

    // Frame 2: s_last on slot 3, tail must be zero-filled
    b0 = bq_re.size();
    for (int k = 0; k < 4; k++) send_beat(DW'(k+1), DW'(16'h100 + k), k == 3);
    check("f2_frame_err", {63'b0, frame_err}, 64'd1);
    check("f2_load_write", {63'b0, core_write}, 64'd1);
    wait_beats(b0 + 8);
    for (int k = 0; k < 8; k++) begin
      check("f2_core_slot_re", 64'(mdl_re[k*DW +: DW]), (k < 4) ? 64'(k + 1) : 64'd0);
      check("f2_core_slot_im", 64'(mdl_im[k*DW +: DW]), (k < 4) ? 64'(16'h100 + k) : 64'd0);
      s = 7 - k;
      check("f2_bin_real", 64'(bq_re[b0+k]), (s < 4) ? 64'(s + 1) : 64'd0);
    end
    tick(); tick(); tick();
    check("f2_exact_beats", 64'(bq_re.size()), 64'(b0 + 8));

    // Frame 3: m_ready stalls 1,0,0,1 during drain
    b0 = bq_re.size();
    for (int k = 0; k < 8; k++) send_beat(DW'(16'h10 + k), DW'(16'h20 + k), k == 7);
    for (int t = 0; t < 20 && !m_valid; t++) tick();
    check("f3_valid_wait", {63'b0, m_valid}, 64'd1);
    for (int c = 0; c < 40 && bq_re.size() < b0 + 8; c++) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      m_ready = rdy;
      check("f3_s_ready_low", {63'b0, s_ready}, 64'd0);
      p_idx = m_index; p_re = m_real; p_im = m_imag;
      tick();
      if (!rdy) begin
        check("f3_hold_index", 64'(m_index), 64'(p_idx));
        check("f3_hold_real",  64'(m_real),  64'(p_re));
        check("f3_hold_imag",  64'(m_imag),  64'(p_im));
      end
    end
    m_ready = 1'b1;
    check("f3_beats", 64'(bq_re.size()), 64'(b0 + 8));
    check("f3_s_ready_after", {63'b0, s_ready}, 64'd1);
    for (int k = 0; k < 8; k++) begin
      check("f3_bin_index", 64'(bq_idx[b0+k]), 64'(k));
      check("f3_bin_real",  64'(bq_re[b0+k]),  64'(16'h17 - k));
      check("f3_bin_imag",  64'(bq_im[b0+k]),  64'(16'h27 - k));
    end
    check("f3_frame_err_sticky", {63'b0, frame_err}, 64'd1);

    // Frame 4: reset pulse in RUN abandons the frame
    for (int k = 0; k < 8; k++) send_beat(DW'(16'h30 + k), DW'(16'h38 + k), k == 7);
    tick();
    check("f4_in_run", {63'b0, core_start}, 64'd1);
    RST = 1'b1;
    tick();
    check("f4_rst_start",   {63'b0, core_start}, 64'd0);
    check("f4_rst_valid",   {63'b0, m_valid},    64'd0);
    check("f4_rst_ferr",    {63'b0, frame_err},  64'd0);
    cs0 = cs_cnt; nb = bq_re.size();
    RST = 1'b0; #1;
    check("f4_s_ready_rel", {63'b0, s_ready}, 64'd1);
    tick(); tick(); tick(); tick();
    check("f4_no_strobes", 64'(cs_cnt), 64'(cs0));
    check("f4_no_beats",   64'(bq_re.size()), 64'(nb));
    check("f4_idle_busy",  {63'b0, busy}, 64'd0);

    // Frame 4b then frame 5 back-to-back with s_valid kept high
    b0 = bq_re.size(); a0 = acc_t.size();
    for (int k = 0; k < 8; k++) send_beat(DW'(16'h40 + k), DW'(16'h48 + k), k == 7);
    for (int k = 0; k < 8; k++) send_beat(DW'(16'h60 + k), DW'(16'h68 + k), k == 7);
    wait_beats(b0 + 16);
    for (int k = 0; k < 8; k++) begin
      check("f4b_bin_real", 64'(bq_re[b0+k]), 64'(16'h47 - k));
      check("f4b_bin_idx",  64'(bq_idx[b0+k]), 64'(k));
      check("f5_bin_real",  64'(bq_re[b0+8+k]), 64'(16'h67 - k));
      check("f5_bin_imag",  64'(bq_im[b0+8+k]), 64'(16'h6f - k));
    end
    check("b2b_accepts", 64'(acc_t.size()), 64'(a0 + 16));
    check("b2b_gap", 64'(acc_t[a0+8] - bq_t[b0+7]), 64'd10);
    check("end_frame_err", {63'b0, frame_err}, 64'd0);
    tick();
    check("end_busy",    {63'b0, busy},    64'd0);
    check("end_m_valid", {63'b0, m_valid}, 64'd0);
    check("never_both_strobes", 64'(both_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
